// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch PC unit
package fetch_pkg;
    localparam int INSTR_BITS = 32;
    localparam int PC_W = 32;

    typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [INSTR_BITS-1:0] instr_a;
        logic [INSTR_BITS-1:0] instr_b;
        logic                  valid_b;
        logic                  pred_taken;
        logic [PC_W-1:0]       pred_target;
    } fetch_bundle_t;
endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: output register plus one-entry skid buffer toward decode
module fetch_out_buf
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  fetch_bundle_t in_data,
    output logic          in_load,
    input  logic          out_ready,
    output logic          out_valid,
    output fetch_bundle_t out_data
);
    logic          r_valid;
    logic          r_skid_valid;
    fetch_bundle_t r_data;
    fetch_bundle_t r_skid;

    // output slot is free when empty or being consumed this cycle
    always_comb begin
        in_load   = !r_valid || out_ready;
        out_valid = r_valid;
        out_data  = r_data;
    end

    // skid entry drains first to keep bundles in order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_data       <= '0;
            r_skid       <= '0;
        end else if (clear) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_data       <= '0;
            r_skid       <= '0;
        end else if (in_load) begin
            if (r_skid_valid) begin
                r_data       <= r_skid;
                r_valid      <= 1'b1;
                r_skid_valid <= in_valid;
                r_skid       <= in_data;
            end else begin
                r_valid <= in_valid;
                if (in_valid) r_data <= in_data;
            end
        end else if (in_valid) begin
            r_skid       <= in_data;
            r_skid_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC register, I-cache request FSM and bundle packing
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int          PC_BITS     = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FETCH_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_BITS-1:0]     pc_out,
    input  logic                   taken_branch_a,
    input  logic                   taken_branch_b,
    input  logic [PC_BITS-1:0]     next_pc_a,
    input  logic [PC_BITS-1:0]     next_pc_b,
    input  logic                   flush_valid,
    input  logic [PC_BITS-1:0]     flush_pc,
    output logic                   icache_req_valid,
    input  logic                   icache_req_ready,
    output logic [PC_BITS-1:0]     icache_req_addr,
    input  logic                   icache_resp_valid,
    input  logic [FETCH_WIDTH-1:0] icache_resp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_BITS-1:0]     out_pc,
    output logic [INSTR_BITS-1:0]  out_instr_a,
    output logic [INSTR_BITS-1:0]  out_instr_b,
    output logic                   out_valid_b,
    output logic                   out_pred_taken,
    output logic [PC_BITS-1:0]     out_pred_target
);
    fetch_state_e       r_state;
    fetch_state_e       w_state;
    logic [PC_BITS-1:0] r_pc;
    logic [PC_BITS-1:0] r_next_pc;
    logic               r_taken;
    logic               r_valid_b;
    logic [PC_BITS-1:0] w_pred_pc;
    logic [PC_BITS-1:0] w_pc;
    logic               w_accept;
    logic               w_resp;
    logic               w_push;
    logic               w_load;
    logic               w_advance;
    fetch_bundle_t      w_in;
    fetch_bundle_t      w_out;

    // predictor choice, FSM next state and PC update
    always_comb begin
        icache_req_valid = (r_state == REQ) && !rst;
        icache_req_addr  = r_pc;
        pc_out           = r_pc;
        w_pred_pc        = taken_branch_a ? next_pc_a : taken_branch_b ? next_pc_b : r_pc + PC_BITS'(8);
        w_accept         = icache_req_valid && icache_req_ready;
        w_resp           = (r_state == WAIT) && icache_resp_valid;
        w_push           = w_resp && !flush_valid;
        w_advance        = !flush_valid && ((w_resp && w_load) || (r_state == HOLD && out_ready));
        w_pc             = flush_valid ? flush_pc : w_advance ? r_next_pc : r_pc;
        w_state          = r_state;
        if (flush_valid)
            w_state = ((r_state == REQ && w_accept) ||
                       ((r_state == WAIT || r_state == DROP) && !icache_resp_valid)) ? DROP : REQ;
        else if (r_state == REQ)
            w_state = w_accept ? WAIT : REQ;
        else if (r_state == WAIT)
            w_state = icache_resp_valid ? (w_load ? REQ : HOLD) : WAIT;
        else if (r_state == HOLD)
            w_state = out_ready ? REQ : HOLD;
        else
            w_state = icache_resp_valid ? REQ : DROP;
        w_in.pc          = r_pc;
        w_in.instr_a     = icache_resp_data[INSTR_BITS-1:0];
        w_in.instr_b     = icache_resp_data[2*INSTR_BITS-1:INSTR_BITS];
        w_in.valid_b     = r_valid_b;
        w_in.pred_taken  = r_taken;
        w_in.pred_target = r_next_pc;
        out_pc           = w_out.pc;
        out_instr_a      = w_out.instr_a;
        out_instr_b      = w_out.instr_b;
        out_valid_b      = w_out.valid_b;
        out_pred_taken   = w_out.pred_taken;
        out_pred_target  = w_out.pred_target;
    end

    // state, PC and prediction latched at request acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= REQ;
            r_pc      <= PC_BITS'(RESET_PC);
            r_next_pc <= '0;
            r_taken   <= 1'b0;
            r_valid_b <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            if (w_accept && r_state == REQ) begin
                r_next_pc <= w_pred_pc;
                r_taken   <= taken_branch_a || taken_branch_b;
                r_valid_b <= !taken_branch_a;
            end
        end
    end

    fetch_out_buf u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_valid),
        .in_valid  (w_push),
        .in_data   (w_in),
        .in_load   (w_load),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (w_out)
    );
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench with I-cache and predictor models
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    logic        clk, rst;
    logic [31:0] pc_out;
    logic        taken_branch_a, taken_branch_b;
    logic [31:0] next_pc_a, next_pc_b;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        icache_req_valid, icache_req_ready;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [63:0] icache_resp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr_a, out_instr_b;
    logic        out_valid_b, out_pred_taken;
    logic [31:0] out_pred_target;

    int errors = 0;
    int checks = 0;
    int lat = 1;
    logic [31:0]   rq[$];
    fetch_bundle_t bq[$];

    fetch_pc_unit dut (
        .clk(clk), .rst(rst), .pc_out(pc_out),
        .taken_branch_a(taken_branch_a), .taken_branch_b(taken_branch_b),
        .next_pc_a(next_pc_a), .next_pc_b(next_pc_b),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .icache_req_addr(icache_req_addr), .icache_resp_valid(icache_resp_valid),
        .icache_resp_data(icache_resp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr_a(out_instr_a), .out_instr_b(out_instr_b),
        .out_valid_b(out_valid_b), .out_pred_taken(out_pred_taken),
        .out_pred_target(out_pred_target)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always_comb begin
        taken_branch_a = (pc_out == 32'h200);
        next_pc_a      = taken_branch_a ? 32'h80 : 32'hDEAD_0000;
        taken_branch_b = (pc_out == 32'h100);
        next_pc_b      = taken_branch_b ? 32'h400 : 32'hBEEF_0000;
    end

    function automatic logic [31:0] ia(input logic [31:0] a);
        return a ^ 32'h1111_0000;
    endfunction
    function automatic logic [31:0] ib(input logic [31:0] a);
        return (a + 32'd4) ^ 32'h2222_0000;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] addr, input logic push, input logic tk,
                         input logic [31:0] tgt, input logic vb);
        fetch_bundle_t b;
        rq.push_back(addr);
        if (push) begin
            b.pc = addr; b.instr_a = ia(addr); b.instr_b = ib(addr);
            b.valid_b = vb; b.pred_taken = tk; b.pred_target = tgt;
            bq.push_back(b);
        end
        for (int n = 0; n < 40 && !icache_req_valid; n++) step();
        if (!icache_req_valid) chk("req_timeout", {31'd0, icache_req_valid}, 32'd1);
        icache_req_ready = 1;
        step();
        icache_req_ready = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && bq.size() != 0; n++) step();
        chk("drain", 32'(bq.size()), 32'd0);
    endtask

    task automatic flush(input logic [31:0] a);
        flush_valid = 1;
        flush_pc    = a;
        step();
        flush_valid = 0;
    endtask

    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    initial begin
        icache_resp_valid = 0;
        icache_resp_data  = '0;
        pend = 0;
        cnt  = 0;
        paddr = '0;
        forever begin
            @(negedge clk);
            if (icache_req_valid && icache_req_ready) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_request: got %h expected none", icache_req_addr);
                end else chk("req_addr", icache_req_addr, rq.pop_front());
                pend = 1; cnt = lat; paddr = icache_req_addr;
            end
            @(posedge clk);
            #1;
            icache_resp_valid = 0;
            if (rst) pend = 0;
            else if (pend) begin
                if (cnt <= 1) begin
                    icache_resp_valid = 1;
                    icache_resp_data  = {ib(paddr), ia(paddr)};
                    pend = 0;
                end else cnt--;
            end
        end
    end

    initial begin
        fetch_bundle_t a, e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                a.pc = out_pc; a.instr_a = out_instr_a; a.instr_b = out_instr_b;
                a.valid_b = out_valid_b; a.pred_taken = out_pred_taken; a.pred_target = out_pred_target;
                checks++;
                if (bq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bundle: got pc %h expected none", out_pc);
                end else begin
                    e = bq.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL bundle: got pc=%h a=%h b=%h vb=%b tk=%b tgt=%h expected pc=%h a=%h b=%h vb=%b tk=%b tgt=%h",
                                 a.pc, a.instr_a, a.instr_b, a.valid_b, a.pred_taken, a.pred_target,
                                 e.pc, e.instr_a, e.instr_b, e.valid_b, e.pred_taken, e.pred_target);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; flush_valid = 0; flush_pc = '0; icache_req_ready = 0; out_ready = 0;
        #1 rst = 1;
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_req_valid", {31'd0, icache_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_valid_b", {31'd0, out_valid_b}, 32'd0);
        chk("rst_pred_taken", {31'd0, out_pred_taken}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_instr_a", out_instr_a, 32'h0);
        chk("rst_target", out_pred_target, 32'h0);
        step(); step();
        rst = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("req_hold_valid", {31'd0, icache_req_valid}, 32'd1);
            chk("req_hold_addr", icache_req_addr, 32'h0);
            step();
        end
        out_ready = 1;
        issue(32'h0,  1, 0, 32'h8,  1);
        issue(32'h8,  1, 0, 32'h10, 1);
        issue(32'h10, 1, 0, 32'h18, 1);
        drain();
        flush(32'h100);
        chk("flush_req_addr", icache_req_addr, 32'h100);
        issue(32'h100, 1, 1, 32'h400, 1);
        issue(32'h400, 1, 0, 32'h408, 1);
        drain();
        flush(32'h200);
        issue(32'h200, 1, 1, 32'h80, 0);
        issue(32'h80,  1, 0, 32'h88, 1);
        drain();
        lat = 3;
        issue(32'h88, 0, 0, 32'h0, 0);
        flush(32'h1000);
        chk("drop_no_req", {31'd0, icache_req_valid}, 32'd0);
        chk("drop_no_out", {31'd0, out_valid}, 32'd0);
        issue(32'h1000, 1, 0, 32'h1008, 1);
        drain();
        lat = 1;
        out_ready = 0;
        issue(32'h1008, 1, 0, 32'h1010, 1);
        issue(32'h1010, 1, 0, 32'h1018, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_pc", out_pc, 32'h1008);
            chk("hold_instr_a", out_instr_a, ia(32'h1008));
            chk("hold_no_req", {31'd0, icache_req_valid}, 32'd0);
            step();
        end
        out_ready = 1;
        drain();
        issue(32'h1018, 0, 0, 32'h0, 0);
        chk("coincident_resp", {31'd0, icache_resp_valid}, 32'd1);
        flush(32'h2000);
        chk("coincident_req", {31'd0, icache_req_valid}, 32'd1);
        chk("coincident_addr", icache_req_addr, 32'h2000);
        chk("coincident_no_out", {31'd0, out_valid}, 32'd0);
        issue(32'h2000, 1, 0, 32'h2008, 1);
        drain();
        lat = 3;
        issue(32'h2008, 0, 0, 32'h0, 0);
        rst = 1;
        #1;
        chk("midrst_pc", pc_out, 32'h0);
        chk("midrst_out_pc", out_pc, 32'h0);
        chk("midrst_req", {31'd0, icache_req_valid}, 32'd0);
        step(); step(); step();
        rst = 0;
        #1;
        chk("postrst_req", {31'd0, icache_req_valid}, 32'd1);
        chk("postrst_addr", icache_req_addr, 32'h0);
        chk("postrst_out", {31'd0, out_valid}, 32'd0);
        lat = 1;
        issue(32'h0, 1, 0, 32'h8, 1);
        drain();
        step(); step();
        chk("rq_empty", 32'(rq.size()), 32'd0);
        chk("bq_empty", 32'(bq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
